btn_press_ctrl: RTL
===================

// Module: btn_press_ctrl
//
// PURPOSE
//   Press-gesture controller for one debounced button.
//   Consumes the debouncer's level and press tick, and classifies each gesture as SHORT, DOUBLE or LONG.
//   Sequences a 4-bit event counter that drives the LEDs: SHORT increments, DOUBLE decrements, LONG clears.
//   Sits between debouncer_fsm and the LED outputs at top level.
//
// PARAMETERS
//   CLK_FREQ   100_000_000  clock frequency, Hz
//   LONG_TIME  1.0          hold time for LONG, s;  LONG_TICKS = CLK_FREQ*LONG_TIME
//   DBL_TIME   0.300        max release-to-repress gap for DOUBLE, s;  DBL_TICKS = CLK_FREQ*DBL_TIME
//
// PORTS
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   db           in   1  debounced button level (1 = pressed)
//   db_tick      in   1  1-cycle pulse on debounced press (0->1)
//   count        out  4  gesture counter
//   short_tick   out  1  1-cycle pulse, SHORT recognised
//   double_tick  out  1  1-cycle pulse, DOUBLE recognised
//   long_tick    out  1  1-cycle pulse, LONG recognised
//   busy         out  1  FSM not in IDLE
//
// BEHAVIOUR
//   - Reset (sync, clk edge with reset=1), incl. mid-gesture:
//     state=IDLE, timer=0, count=0, all ticks=0, busy=0. No event is emitted for the aborted gesture.
//   - Timer: single up-counter, width $clog2(max(LONG_TICKS,DBL_TICKS)+1).
//     Cleared on every state change; otherwise increments.
//   - FSM (registered, ticks and count updated on the same edge):
//     IDLE:      db_tick -> PRESS1
//     PRESS1:    db=0 -> GAP
//                timer==LONG_TICKS-1 with db=1 -> LONG_HELD; long_tick=1; count<=0
//     LONG_HELD: db=0 -> IDLE; no further events while held
//     GAP:       db_tick -> PRESS2
//                timer==DBL_TICKS-1 -> IDLE; short_tick=1; count<=count+1
//     PRESS2:    db=0 -> IDLE; double_tick=1; count<=count-1. No LONG detection in PRESS2.
//   - Priority: in GAP, db_tick on the same cycle as timeout -> DOUBLE path wins (PRESS2).
//   - db_tick is ignored in PRESS1, PRESS2 and LONG_HELD.
//   - Latency:
//     SHORT: DBL_TICKS cycles after the release edge is sampled.
//     LONG: LONG_TICKS cycles after the db_tick.
//     DOUBLE: 1 cycle after the second release.
//   - Arithmetic: 4-bit modulo; 15+1 -> 0, 0-1 -> 15 (unless saturation is enabled).
//   - At most one of short/double/long_tick is high on any cycle.
//
// CONFIGURATION
//   BTN_CTRL_SATURATE_EN defined:     count saturates; SHORT at 15 holds 15; DOUBLE at 0 holds 0.
//                                     Ticks still pulse.
//   BTN_CTRL_SATURATE_EN not defined: modulo-16 wrap as above.
//
// STRUCTURE
//   btn_ctrl_pkg:
//     typedef enum logic [2:0] {IDLE, PRESS1, LONG_HELD, GAP, PRESS2} btn_state_t
//     function ticks(freq, time) returning integer cycle count
//   Sub-module btn_timer: clear/enable up-counter, WIDTH parameter, outputs q.
//   FSM and count register stay in btn_press_ctrl.
//
// TESTING  (CLK_FREQ=1000, LONG_TIME=0.05 -> 50 ticks, DBL_TIME=0.02 -> 20 ticks)
//   - Press 10 cyc, release -> short_tick exactly 20 cyc after release; count 0->1.
//   - Press 5, gap 8, press 5, release -> double_tick 1 cyc after 2nd release; count 0->15 (wrap).
//     With saturation enabled, count stays 0.
//   - count=7; hold 80 cyc -> long_tick at cyc 50 after db_tick; count=0; no event on release.
//   - Press, release, db_tick on the exact timeout cycle -> PRESS2; no short_tick; double on release.
//   - Assert reset while in GAP -> count=0, busy=0 next cycle; no short_tick ever appears.
//   - 16 short presses -> count wraps 15->0 (or holds 15 with BTN_CTRL_SATURATE_EN).

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the button press controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package btn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HELD,
    GAP,
    PRESS2
  } btn_state_t;

  // Seconds to clock cycles, rounded to the nearest cycle so that values
  // like 1000 * 0.05 do not lose a tick to floating-point truncation.
  function automatic integer ticks(input integer freq, input real secs);
    return $rtoi((freq * secs) + 0.5);
  endfunction

  function automatic integer max_int(input integer a, input integer b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_timer.sv
// Free-running up-counter with synchronous clear, used to time press/gap phases.
// Latency: q reflects clr/en one cycle after they are sampled.
// Backpressure: none; clr and en are acted on every cycle.
module btn_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Clear has priority over counting; the counter wraps naturally when idle.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/btn_press_ctrl.sv
// Classifies button gestures (SHORT/DOUBLE/LONG) and steps a 4-bit LED counter.
// Latency: SHORT DBL_TICKS after release, LONG LONG_TICKS after press, DOUBLE 1 after 2nd release.
// Backpressure: none; db/db_tick are consumed every cycle. BTN_CTRL_SATURATE_EN: saturating count.
module btn_press_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter integer CLK_FREQ  = 100_000_000,
  parameter real    LONG_TIME = 1.0,
  parameter real    DBL_TIME  = 0.300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db,
  input  logic       db_tick,
  output logic [3:0] count,
  output logic       short_tick,
  output logic       double_tick,
  output logic       long_tick,
  output logic       busy
);

  localparam integer LONG_TICKS = ticks(CLK_FREQ, LONG_TIME);
  localparam integer DBL_TICKS  = ticks(CLK_FREQ, DBL_TIME);
  localparam integer TW         = $clog2(max_int(LONG_TICKS, DBL_TICKS) + 1);

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] DBL_LAST  = TW'(DBL_TICKS - 1);

  btn_state_t    state_q;
  btn_state_t    state_d;
  logic [TW-1:0] timer_q;
  logic          timer_clr;
  logic [3:0]    count_d;
  logic [3:0]    count_inc;
  logic [3:0]    count_dec;
  logic          short_d;
  logic          double_d;
  logic          long_d;

  // Phase timer restarts on every state transition so each phase times from zero.
  btn_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (1'b1),
    .q     (timer_q)
  );

  assign timer_clr = (state_d != state_q);
  assign busy      = (state_q != IDLE);

`ifdef BTN_CTRL_SATURATE_EN
  assign count_inc = (count == 4'hF) ? count : count + 4'd1;
  assign count_dec = (count == 4'h0) ? count : count - 4'd1;
`else
  assign count_inc = count + 4'd1;
  assign count_dec = count - 4'd1;
`endif

  // Gesture FSM: next state, next count and the event pulse for this cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (db_tick) state_d = PRESS1;
      end
      PRESS1: begin
        // A release on the timeout cycle is still a short press.
        if (!db) begin
          state_d = GAP;
        end else if (timer_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          count_d = 4'd0;
        end
      end
      LONG_HELD: begin
        if (!db) state_d = IDLE;
      end
      GAP: begin
        // A re-press on the timeout cycle still counts as a double.
        if (db_tick) begin
          state_d = PRESS2;
        end else if (timer_q == DBL_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
          count_d = count_inc;
        end
      end
      PRESS2: begin
        if (!db) begin
          state_d  = IDLE;
          double_d = 1'b1;
          count_d  = count_dec;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and event pulses all update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count       <= 4'd0;
      short_tick  <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count       <= count_d;
      short_tick  <= short_d;
      double_tick <= double_d;
      long_tick   <= long_d;
    end
  end

endmodule
